seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_if.sv | 20 ++
 rtl/seg_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of note-history inputs and multiplexed 4-digit display outputs
// for the segment scan controller.
interface seg_scan_ctrl_if;
  logic       note_valid;
  logic [3:0] note;
  logic       clear;
  logic [7:0] seg;
  logic [3:0] an;
  logic [2:0] occupancy;

  modport master (
    output note_valid, note, clear,
    input  seg, an, occupancy
  );

  modport slave (
    input  note_valid, note, clear,
    output seg, an, occupancy
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-deep note history shown on a time-multiplexed active-low 4-digit
// seven-segment display, with anode-off blanking at the start of every slot.
module seg_scan_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PCNT_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYC);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  logic [PW-1:0] pcnt_r;
  logic [PW-1:0] pcnt_nxt_s;
  logic [1:0]    d_r;
  logic [1:0]    d_nxt_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [3:0]    code_r [4];
  logic [3:0]    valid_r;
  logic [2:0]    occ_r;
  logic [7:0]    seg_r;
  logic [7:0]    seg_nxt_s;
  logic [3:0]    an_r;
  logic [3:0]    an_nxt_s;

  // Bit order P,G,F,E,D,C,B,A; codes above 7 render blank.
  function automatic logic [7:0] note_decode(input logic [3:0] code);
    logic [7:0] pattern;
    case (code)
      4'd0:    pattern = 8'b11000110;
      4'd1:    pattern = 8'b10000011;
      4'd2:    pattern = 8'b10001000;
      4'd3:    pattern = 8'b10010000;
      4'd4:    pattern = 8'b10001110;
      4'd5:    pattern = 8'b10000110;
      4'd6:    pattern = 8'b10100001;
      4'd7:    pattern = 8'b01000110;
      default: pattern = 8'hFF;
    endcase
    return pattern;
  endfunction

  // Prescaler and digit index next values.
  always_comb begin
    pcnt_nxt_s = pcnt_r + PW'(1);
    d_nxt_s    = d_r;
    if (pcnt_r == PCNT_MAX) begin
      pcnt_nxt_s = '0;
      d_nxt_s    = d_r + 2'd1;
    end else begin
      pcnt_nxt_s = pcnt_r + PW'(1);
    end
  end

  // Prescaler and digit index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_r <= '0;
      d_r    <= 2'd0;
    end else begin
      pcnt_r <= pcnt_nxt_s;
      d_r    <= d_nxt_s;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_BLANK;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // State tracks the prescaler so it always matches pcnt_r after each edge.
  always_comb begin
    state_nxt_s = ST_BLANK;
    case (state_r)
      ST_BLANK: begin
        if (pcnt_nxt_s >= BLANK_LIM) state_nxt_s = ST_DRIVE;
        else                         state_nxt_s = ST_BLANK;
      end
      ST_DRIVE: begin
        if (pcnt_nxt_s < BLANK_LIM) state_nxt_s = ST_BLANK;
        else                        state_nxt_s = ST_DRIVE;
      end
      default: state_nxt_s = ST_BLANK;
    endcase
  end

  // Output decode from current state, digit and buffer contents.
  always_comb begin
    an_nxt_s  = 4'b1111;
    seg_nxt_s = 8'hFF;
    case (state_r)
      ST_BLANK: begin
        an_nxt_s  = 4'b1111;
        seg_nxt_s = 8'hFF;
      end
      ST_DRIVE: begin
        an_nxt_s = ~(4'b0001 << d_r);
        if (valid_r[d_r]) seg_nxt_s = note_decode(code_r[d_r]);
        else              seg_nxt_s = 8'hFF;
      end
      default: begin
        an_nxt_s  = 4'b1111;
        seg_nxt_s = 8'hFF;
      end
    endcase
  end

  // Registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= 8'hFF;
      an_r  <= 4'b1111;
    end else begin
      seg_r <= seg_nxt_s;
      an_r  <= an_nxt_s;
    end
  end

  // History buffer: clear wins over a coincident push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) code_r[i] <= 4'd0;
      valid_r <= 4'b0000;
      occ_r   <= 3'd0;
    end else if (bus.clear) begin
      valid_r <= 4'b0000;
      occ_r   <= 3'd0;
    end else if (bus.note_valid) begin
      code_r[3] <= code_r[2];
      code_r[2] <= code_r[1];
      code_r[1] <= code_r[0];
      code_r[0] <= bus.note;
      valid_r   <= {valid_r[2:0], 1'b1};
      occ_r     <= (occ_r == 3'd4) ? 3'd4 : occ_r + 3'd1;
    end else begin
      valid_r <= valid_r;
      occ_r   <= occ_r;
    end
  end

  assign bus.seg       = seg_r;
  assign bus.an        = an_r;
  assign bus.occupancy = occ_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: per-cycle scoreboard against a
// behavioural model plus table-driven push/clear vectors and scan checks.
module tb_seg_scan_ctrl;
  localparam int TICK_DIV  = 8;
  localparam int BLANK_CYC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.TICK_DIV(TICK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic [2:0] occ;
  } obs_t;

  typedef struct {
    logic           nv;
    logic [3:0]     note;
    logic           clr;
    logic [2:0]     exp_occ;
    logic           scan;
    logic [3:0][7:0] disp;
  } vec_t;

  obs_t sb_q[$];
  vec_t tbl[17];

  int         m_pcnt;
  int         m_d;
  logic [3:0] m_code [4];
  logic [3:0] m_valid;
  int         m_occ;

  function automatic logic [7:0] ref_dec(input logic [3:0] c);
    case (c)
      4'd0:    return 8'hC6;
      4'd1:    return 8'h83;
      4'd2:    return 8'h88;
      4'd3:    return 8'h90;
      4'd4:    return 8'h8E;
      4'd5:    return 8'h86;
      4'd6:    return 8'hA1;
      4'd7:    return 8'h46;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pcnt  = 0;
    m_d     = 0;
    m_valid = 4'b0000;
    m_occ   = 0;
    for (int i = 0; i < 4; i++) m_code[i] = 4'd0;
  endtask

  // One clock: drive inputs, push the model's expectation, compare after the edge.
  task automatic step(input logic nv, input logic [3:0] nt, input logic clr);
    obs_t e;
    obs_t got;
    bus.note_valid = nv;
    bus.note       = nt;
    bus.clear      = clr;
    if (m_pcnt < BLANK_CYC) begin
      e.an  = 4'hF;
      e.seg = 8'hFF;
    end else begin
      e.an        = 4'hF;
      e.an[m_d]   = 1'b0;
      e.seg       = m_valid[m_d] ? ref_dec(m_code[m_d]) : 8'hFF;
    end
    if (clr) begin
      m_valid = 4'b0000;
      m_occ   = 0;
    end else if (nv) begin
      for (int i = 3; i > 0; i--) begin
        m_code[i]  = m_code[i-1];
        m_valid[i] = m_valid[i-1];
      end
      m_code[0]  = nt;
      m_valid[0] = 1'b1;
      if (m_occ < 4) m_occ++;
    end
    if (m_pcnt == TICK_DIV - 1) begin
      m_pcnt = 0;
      m_d    = (m_d + 1) % 4;
    end else begin
      m_pcnt++;
    end
    e.occ = 3'(m_occ);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.note_valid = 1'b0;
    bus.clear      = 1'b0;
    got = {bus.seg, bus.an, bus.occupancy};
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      check("scoreboard", 32'(got), 32'(sb_q.pop_front()));
    end
    check("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
  endtask

  // 32 idle cycles; every driven digit must show its expected pattern.
  task automatic run_scan(input logic [3:0][7:0] disp);
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        if (bus.an[i] == 1'b0) check("digit_seg", 32'(bus.seg), 32'(disp[i]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pos;
    int  slot;
    logic [3:0] exp_an;
    logic found;

    tbl[0]  = '{1'b0, 4'd0, 1'b1, 3'd0, 1'b0, 32'hFFFFFFFF};
    tbl[1]  = '{1'b1, 4'd2, 1'b0, 3'd1, 1'b0, 32'hFFFFFFFF};
    tbl[2]  = '{1'b1, 4'd5, 1'b0, 3'd2, 1'b0, 32'hFFFFFFFF};
    tbl[3]  = '{1'b1, 4'd0, 1'b0, 3'd3, 1'b1, {8'hFF, 8'h88, 8'h86, 8'hC6}};
    tbl[4]  = '{1'b0, 4'd0, 1'b1, 3'd0, 1'b0, 32'hFFFFFFFF};
    tbl[5]  = '{1'b1, 4'd0, 1'b0, 3'd1, 1'b0, 32'hFFFFFFFF};
    tbl[6]  = '{1'b1, 4'd1, 1'b0, 3'd2, 1'b0, 32'hFFFFFFFF};
    tbl[7]  = '{1'b1, 4'd2, 1'b0, 3'd3, 1'b0, 32'hFFFFFFFF};
    tbl[8]  = '{1'b1, 4'd3, 1'b0, 3'd4, 1'b0, 32'hFFFFFFFF};
    tbl[9]  = '{1'b1, 4'd4, 1'b0, 3'd4, 1'b0, 32'hFFFFFFFF};
    tbl[10] = '{1'b1, 4'd5, 1'b0, 3'd4, 1'b1, {8'h88, 8'h90, 8'h8E, 8'h86}};
    tbl[11] = '{1'b0, 4'd0, 1'b1, 3'd0, 1'b0, 32'hFFFFFFFF};
    tbl[12] = '{1'b1, 4'd1, 1'b0, 3'd1, 1'b0, 32'hFFFFFFFF};
    tbl[13] = '{1'b1, 4'd2, 1'b0, 3'd2, 1'b0, 32'hFFFFFFFF};
    tbl[14] = '{1'b1, 4'd7, 1'b1, 3'd0, 1'b1, 32'hFFFFFFFF};
    tbl[15] = '{1'b1, 4'd9, 1'b0, 3'd1, 1'b1, 32'hFFFFFFFF};
    tbl[16] = '{1'b1, 4'd7, 1'b0, 3'd2, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h46}};

    rst            = 1'b1;
    bus.note_valid = 1'b0;
    bus.note       = 4'd0;
    bus.clear      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(bus.seg), 32'hFF);
    check("reset_an", 32'(bus.an), 32'hF);
    check("reset_occ", 32'(bus.occupancy), 32'd0);
    rst = 1'b0;

    // Idle scan straight out of reset: two blank cycles then six driven per slot.
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 4'd0, 1'b0);
      pos  = (k - 1) % 8;
      slot = (k - 1) / 8;
      exp_an = 4'hF;
      if (pos >= 2) exp_an[slot] = 1'b0;
      check("idle_an", 32'(bus.an), 32'(exp_an));
      check("idle_seg", 32'(bus.seg), 32'hFF);
      check("idle_occ", 32'(bus.occupancy), 32'd0);
    end

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].nv, tbl[i].note, tbl[i].clr);
      check("table_occ", 32'(bus.occupancy), 32'(tbl[i].exp_occ));
      if (tbl[i].scan) run_scan(tbl[i].disp);
    end

    // Asynchronous reset between edges at pcnt=5, d=2 with three entries.
    step(1'b1, 4'd3, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (m_pcnt == 5 && m_d == 2) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 4'd0, 1'b0);
    end
    check("reach_pcnt5_d2", 32'(found), 32'd1);
    check("pre_reset_occ", 32'(bus.occupancy), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("async_seg", 32'(bus.seg), 32'hFF);
    check("async_an", 32'(bus.an), 32'hF);
    check("async_occ", 32'(bus.occupancy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb_q.delete();
    repeat (3) step(1'b0, 4'd0, 1'b0);
    check("restart_an_d0", 32'(bus.an), 32'hE);
    run_scan(32'hFFFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
